// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, read-only instruction cache sitting between the fetch unit and
// the instruction memory. One request is outstanding at a time. A request is
// sampled in IDLE, looked up in the array and answered with a full line plus
// its line-aligned PC. Misses refill the line from a line-wide memory port.
// The memory request uses valid/ready. The memory response is a single
// valid-only beat.
//
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss statistics
// counters hit_cnt_o and miss_cnt_o.
//
// Ports
//   clk_i            clock
//   rst_n_i          asynchronous active-low reset
//   flush_i          pipeline flush (cancels or drops the current request)
//   read_req_i       fetch read request (level, sampled only in IDLE)
//   pc_i             fetch PC; the in-line offset bits are ignored
//   read_done_o      one-cycle pulse: cache_out_o holds the requested line
//   cache_out_o      {line-aligned pc, line data}; registered
//   mem_req_valid_o  refill request valid
//   mem_req_ready_i  memory accepts the refill request
//   mem_addr_o       line-aligned refill address
//   mem_resp_valid_i refill data valid (single beat)
//   mem_resp_data_i  refill line
//   hit_cnt_o        saturating lookup-hit count  (ICACHE_STATS_EN only)
//   miss_cnt_o       saturating lookup-miss count (ICACHE_STATS_EN only)
// -----------------------------------------------------------------------------
package mmm_pkg;
    localparam int XLEN          = 32;
    localparam int ILEN          = 32;
    localparam int OFFSET        = 2;   // byte offset inside one instruction
    localparam int ICACHE_OFFSET = 2;   // log2(instructions per line)
    localparam int LINE_W        = ILEN << ICACHE_OFFSET;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [LINE_W-1:0] line;
    } icache_out_t;
endpackage

module icache_responder
    import mmm_pkg::*;
#(
    parameter int NSETS       = 16,
    parameter int MEM_LAT_MAX = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              read_req_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              read_done_o,
    output icache_out_t       cache_out_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [LINE_W-1:0] mem_resp_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int LSB   = OFFSET + ICACHE_OFFSET;
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = XLEN - LSB - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              drop_q;

    logic [LINE_W-1:0] data_mem [NSETS];
    logic [TAG_W-1:0]  tag_mem  [NSETS];
    logic              valid_q  [NSETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   pc_aligned;
    logic              hit;
    logic              fill_en;

    assign idx        = pc_q[LSB +: IDX_W];
    assign tag        = pc_q[XLEN-1 -: TAG_W];
    assign pc_aligned = {pc_q[XLEN-1:LSB], {LSB{1'b0}}};
    assign hit        = valid_q[idx] && (tag_mem[idx] == tag);
    assign fill_en    = (state_q == MEM_WAIT) && mem_resp_valid_i;

    // The in-line offset of the PC and the bench-only latency bound carry no
    // information for the datapath.
    logic unused_bits;
    assign unused_bits = ^{pc_q[LSB-1:0], (MEM_LAT_MAX != 0)};

    // A flush arriving in the response cycle still suppresses the pulse, so
    // this output cannot be registered one cycle earlier.
    assign read_done_o = (state_q == RESP) && !drop_q && !flush_i;

    // Tag/data arrays: no reset, written only by a refill. A refill always
    // overwrites the set; there is nothing to write back.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_mem[idx] <= mem_resp_data_i;
            tag_mem[idx]  <= tag;
        end
    end

    // Per-set valid bits, cleared only by reset.
    genvar gi;
    generate
        for (gi = 0; gi < NSETS; gi++) begin : g_valid
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    valid_q[gi] <= 1'b0;
                end else if (fill_en && (idx == IDX_W'(gi))) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            drop_q          <= 1'b0;
            cache_out_o     <= '0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
`ifdef ICACHE_STATS_EN
            hit_cnt_o       <= '0;
            miss_cnt_o      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A flush in the same cycle kills the new request.
                    if (read_req_i && !flush_i) begin
                        pc_q    <= pc_i;
                        drop_q  <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef ICACHE_STATS_EN
                    // Counted even when the lookup is flushed.
                    if (hit) begin
                        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
                    end else begin
                        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
                    end
`endif
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (hit) begin
                        cache_out_o <= '{pc: pc_aligned, line: data_mem[idx]};
                        state_q     <= RESP;
                    end else begin
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= pc_aligned;
                        state_q         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    // A flush cannot retract the request once it is visible;
                    // the refill completes and only the response is dropped.
                    if (flush_i) drop_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state_q         <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (flush_i) drop_q <= 1'b1;
                    if (mem_resp_valid_i) begin
                        cache_out_o <= '{pc: pc_aligned, line: mem_resp_data_i};
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
    import mmm_pkg::*;

    localparam int NSETS = 16;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              flush_i;
    logic              read_req_i;
    logic [31:0]       pc_i;
    logic              read_done_o;
    icache_out_t       cache_out_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [31:0]       mem_addr_o;
    logic              mem_resp_valid_i;
    logic [127:0]      mem_resp_data_i;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
`endif

    icache_responder #(.NSETS(NSETS), .MEM_LAT_MAX(0)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .flush_i          (flush_i),
        .read_req_i       (read_req_i),
        .pc_i             (pc_i),
        .read_done_o      (read_done_o),
        .cache_out_o      (cache_out_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: which line address each set currently holds.
    bit          m_valid [NSETS];
    logic [31:0] m_line  [NSETS];
    int          m_hits  = 0;
    int          m_miss  = 0;

    // Memory contents are a fixed function of the line address.
    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = ((a + 32'(k)) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("hit_cnt", hit_cnt_o, m_hits);
        check("miss_cnt", miss_cnt_o, m_miss);
`endif
    endtask

    // One fetch transaction. stall: cycles with ready low before acceptance;
    // wt: idle cycles between acceptance and the response beat; flush_at:
    // cycle after the sample edge in which flush_i is pulsed (0 = none).
    task automatic fetch(input logic [31:0] pc, input int stall, input int wt, input int flush_at);
        logic [31:0] aligned;
        int          idx, end_c, req_cycles, addr_bad, pulses, pulse_c, acc_c;
        bit          hit_m, aborted, exp_pulse;
        aligned   = {pc[31:4], 4'b0};
        idx       = int'(pc[7:4]);
        hit_m     = m_valid[idx] && (m_line[idx] == aligned);
        aborted   = (flush_at == 1);
        end_c     = (hit_m || aborted) ? 2 : 4 + stall + wt;
        exp_pulse = (flush_at < 1) || (flush_at > end_c);
        if (hit_m) m_hits++; else m_miss++;
        req_cycles = 0; addr_bad = 0; pulses = 0; pulse_c = 0; acc_c = 0;

        @(negedge clk_i);
        read_req_i = 1'b1;
        pc_i       = pc;
        @(posedge clk_i);
        #1;
        read_req_i = 1'b0;
        pc_i       = $urandom;   // must not matter once the request is taken

        for (int c = 1; c <= end_c + 2; c++) begin
            @(negedge clk_i);
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = '0;
            mem_req_ready_i  = 1'b0;
            if (mem_req_valid_o) begin
                req_cycles++;
                if (mem_addr_o !== aligned) addr_bad++;
                if (req_cycles > stall) begin
                    mem_req_ready_i = 1'b1;
                    acc_c = c;
                    // A response beat coincident with acceptance must be ignored.
                    if ($urandom_range(0, 1) == 1) begin
                        mem_resp_valid_i = 1'b1;
                        mem_resp_data_i  = ~mem_line(aligned);
                    end
                end
            end else if (acc_c > 0 && c == acc_c + 1 + wt) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = mem_line(aligned);
            end
            flush_i = (c == flush_at);
            #1;
            if (read_done_o) begin
                pulses++;
                pulse_c = c;
            end
        end
        @(negedge clk_i);
        flush_i = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;

        $display("fetch pc=%h hit=%0d stall=%0d wait=%0d flush_at=%0d pulses=%0d at=%0d",
                 pc, hit_m, stall, wt, flush_at, pulses, pulse_c);
        check("pulse_count", pulses, exp_pulse ? 1 : 0);
        if (exp_pulse) begin
            check("pulse_latency", pulse_c, end_c);
            check("cache_out", cache_out_o, {aligned, mem_line(aligned)});
        end
        check("mem_req_cycles", req_cycles, (hit_m || aborted) ? 0 : stall + 1);
        check("mem_addr_stable", addr_bad, 0);
        if (!hit_m && !aborted) begin
            m_valid[idx] = 1'b1;
            m_line[idx]  = aligned;
        end
        check_stats();
    endtask

    initial begin
        int pulses;
        rst_n_i = 1'b0; flush_i = 1'b0; read_req_i = 1'b0; pc_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_read_done", read_done_o, 0);
        check("rst_cache_out", cache_out_o, 0);
        check("rst_mem_req_valid", mem_req_valid_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check_stats();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Cold miss, then a hit in the same line.
        fetch(32'h0000_0100, 0, 1, 0);
        fetch(32'h0000_0104, 0, 0, 0);
        // Conflict in set 0: both lines refetched.
        fetch(32'h0000_0200, 1, 0, 0);
        fetch(32'h0000_0100, 0, 2, 0);
        // Flush in MEM_WAIT: no pulse, but the line is filled and then hits.
        fetch(32'h0000_0300, 0, 3, 4);
        fetch(32'h0000_0300, 0, 0, 0);
        // Backpressure: ready low for 5 cycles.
        fetch(32'h0000_0400, 5, 1, 0);
        // Flush during LOOKUP of a miss: no refill, so the next access misses.
        fetch(32'h0000_0510, 0, 0, 1);
        fetch(32'h0000_0510, 0, 0, 0);
        // Index wrap: last set then set 0.
        fetch(32'h0000_00F0, 0, 0, 0);
        fetch(32'h0000_0008, 0, 0, 0);

        // Flush wins over a same-cycle request in IDLE.
        @(negedge clk_i);
        read_req_i = 1'b1; flush_i = 1'b1; pc_i = 32'h0000_0700;
        @(negedge clk_i);
        read_req_i = 1'b0; flush_i = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1;
            if (read_done_o || mem_req_valid_o) pulses++;
        end
        check("flush_beats_req", pulses, 0);

        // Reset in MEM_WAIT, then a stale response beat.
        @(negedge clk_i);
        read_req_i = 1'b1; pc_i = 32'h0000_0900;
        @(posedge clk_i);
        #1 read_req_i = 1'b0;
        @(negedge clk_i);                    // LOOKUP
        @(negedge clk_i);                    // MEM_REQ
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);                    // MEM_WAIT
        mem_req_ready_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check("midrst_mem_req_valid", mem_req_valid_o, 0);
        check("midrst_cache_out", cache_out_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_miss = 0;
        mem_resp_valid_i = 1'b1; mem_resp_data_i = mem_line(32'h0000_0900);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (read_done_o) pulses++;
            @(negedge clk_i);
            mem_resp_valid_i = 1'b0;
        end
        check("stale_resp_no_pulse", pulses, 0);
        check_stats();
        fetch(32'h0000_0100, 0, 0, 0);       // must miss again
        fetch(32'h0000_0900, 0, 0, 0);       // stale beat did not fill

        // Randomised traffic over 24 lines mapped onto 8 sets.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            int fl;
            pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 4)
               | 32'($urandom_range(0, 15));
            fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
            fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
